// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch queue entry layout.
package cpu_pkg;

    localparam int unsigned CPU_PC_W   = 16;
    localparam int unsigned CPU_INST_W = 16;
    localparam logic [CPU_PC_W-1:0] CPU_RESET_PC = '0;

    typedef struct packed {
        logic [CPU_PC_W-1:0]   pc;
        logic [CPU_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and branch redirect.
// IF_PERF_CNT_EN adds the perf_fetched / perf_killed counters to the bus.
interface inst_fetch_queue_if
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W   = CPU_PC_W,
    parameter int unsigned INST_W = CPU_INST_W
);

    logic              branch_to_new;
    logic [PC_W-1:0]   branch_pc;
    logic              mem_rden;
    logic [PC_W-1:0]   mem_rdaddress;
    logic [INST_W-1:0] mem_q;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_killed;
`endif

    modport master (
        input  branch_to_new, branch_pc, mem_q, inst_ready,
        output mem_rden, mem_rdaddress, inst_valid, inst, pc
`ifdef IF_PERF_CNT_EN
        , output perf_fetched, perf_killed
`endif
    );

    modport slave (
        output branch_to_new, branch_pc, mem_q, inst_ready,
        input  mem_rden, mem_rdaddress, inst_valid, inst, pc
`ifdef IF_PERF_CNT_EN
        , input perf_fetched, perf_killed
`endif
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-2 depth, simultaneous push/pop (also when full), single-cycle flush.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    // Storage is cleared so head reads as zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: sequential prefetch into a 1-cycle memory, buffered toward decode,
// flushed on branch redirect. Optional IF_PERF_CNT_EN adds fetched/killed counters.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = CPU_PC_W,
    parameter int unsigned     INST_W   = CPU_INST_W,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(CPU_RESET_PC)
) (
    input logic                clk,
    input logic                rst_n,
    inst_fetch_queue_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [PC_W-1:0] req_pc_q;
    logic [PC_W-1:0] resp_pc_q;
    logic            inflight_q;
    logic [PC_W-1:0] fetch_addr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]  occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic            flush;
    logic            inst_valid;
    entry_t          head;
    entry_t          wentry;

    // Slots already promised to an outstanding read count against capacity.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue      = bus.branch_to_new | (occupancy < (CNT_W+1)'(DEPTH));
    assign fetch_addr = bus.branch_to_new ? bus.branch_pc : req_pc_q;
    assign flush      = bus.branch_to_new;
    assign push       = inflight_q & ~bus.branch_to_new;
    assign inst_valid = (count != '0) & ~bus.branch_to_new;
    assign pop        = inst_valid & bus.inst_ready;
    assign wentry     = {resp_pc_q, bus.mem_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q   <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q  <= fetch_addr + PC_W'(1);
                resp_pc_q <= fetch_addr;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(entry_t))
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .wdata(wentry),
        .count(count),
        .rdata(head)
    );

    // Read enable is held off for the whole reset interval.
    assign bus.mem_rden      = issue & rst_n;
    assign bus.mem_rdaddress = fetch_addr;
    assign bus.inst_valid    = inst_valid;
    assign bus.inst          = head.inst;
    assign bus.pc            = head.pc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_killed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_killed_q  <= '0;
        end else begin
            if (pop) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (bus.branch_to_new) begin
                perf_killed_q <= perf_killed_q + 32'(count) + 32'(inflight_q);
            end
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_killed  = perf_killed_q;
`endif

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised instruction-fetch stage with a prefetch queue. It streams sequential PCs into a synchronous-read instruction memory (1-cycle latency) and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO. It hands them to decode over a valid/ready handshake and flushes cleanly on branch redirect. It sits between the instruction memory interface and the decode stage, and adds backpressure and buffering on top of a plain fetch-then-register stage.

Parameters:
PC_W, 16, PC and memory address width
INST_W, 16, instruction word width
DEPTH, 4, prefetch FIFO entries; power of 2, at least 2
RESET_PC, 0, first PC fetched after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
branch_to_new  in  1  redirect pulse from execute
branch_pc  in  PC_W  redirect target, valid with branch_to_new
mem_rden  out  1  instruction memory read enable
mem_rdaddress  out  PC_W  instruction memory read address
mem_q  in  INST_W  read data, valid the cycle after mem_rden
inst_valid  out  1  head entry valid to decode
inst_ready  in  1  decode accepts head entry
inst  out  INST_W  head instruction
pc  out  PC_W  PC of head instruction

Behaviour:
- Reset is async assert, sync release. While reset is asserted:
  - req_pc = RESET_PC
  - FIFO empty, inflight = 0
  - inst_valid = 0, mem_rden = 0
  - inst and pc read as 0
- Issue rule: issue = branch_to_new | (count + inflight < DEPTH). mem_rden = issue.
- mem_rdaddress is combinational: branch_pc when branch_to_new, else req_pc.
- On issue:
  - req_pc <= mem_rdaddress + 1, modulo 2^PC_W (wraps 0xFFFF -> 0x0000 at PC_W=16).
  - inflight <= 1, and the issued address is recorded in resp_pc.
- Without issue: inflight <= 0.
- Response: the cycle after an issue, mem_q is pushed as {resp_pc, mem_q}, unless killed.
- Kill: a response returning in a cycle with branch_to_new is dropped. The request issued in that cycle (to branch_pc) becomes the new inflight.
- Flush on branch_to_new: count <= 0, pointers reset. Any push in that cycle is suppressed.
- Output: inst_valid = (count != 0) & ~branch_to_new. inst and pc come from the FIFO head.
- Pop = inst_valid & inst_ready. Push and pop in the same cycle are allowed, including when full.
- Latency:
  - First fetch is issued the cycle after rst_n rises.
  - Redirect at cycle N -> target instruction inst_valid at cycle N+2.
  - Sustained throughput is 1 instruction/cycle when inst_ready is held high.
- Full: no issue while count + inflight == DEPTH. The issue resumes the cycle after a pop, with no overrun ever.
- Empty: inst_valid = 0, and inst/pc hold the stale head (don't-care).
- inst_ready low with inst_valid high: inst and pc stay stable until popped or flushed.
- Back-to-back branch_to_new: the last one wins, and every earlier in-flight response is killed.
- Reset mid-operation: everything returns to reset values immediately, and any pending response is discarded.

Optional Feature:
- IF_PERF_CNT_EN defined: adds outputs perf_fetched (32-bit, increments on each pop) and perf_killed (32-bit, increments on each dropped response plus each flushed valid entry, count added). Both clear on reset and wrap at 2^32.
- Undefined: neither port nor counter exists, and the logic is otherwise identical.

Decomposition:
- Package cpu_pkg:
  - PC_W / INST_W defaults and RESET_PC constant.
  - Typedef fetch_entry_t = {pc, inst}.
- One sub-module, fetch_fifo:
  - Parametrised by DEPTH and entry width.
  - push, pop, flush, count, head data.
  - Async active-low reset on clk/rst_n.
- The top level holds the issue/inflight/kill logic and req_pc.

Test Plan:
- Reset release, inst_ready=1: mem_rdaddress 0,1,2,3... on consecutive cycles. inst_valid from cycle 2, with pc/inst matching a memory preload (inst = addr XOR 16'hA5A5).
- inst_ready=0 from start, DEPTH=4: exactly 4 issues then mem_rden=0. inst_valid stays high with pc=0 stable. Raise inst_ready: pcs 0..3 popped in order, then fetching resumes at 4.
- Queue holds pcs 5..8 with a fetch in flight, branch_to_new with branch_pc=0x0040:
  - inst_valid=0 that cycle.
  - Next pc delivered is 0x0040, two cycles later.
  - No pc 5..9 ever delivered afterwards.
- branch_to_new on two consecutive cycles (0x0100, then 0x0200): first delivered pc is 0x0200, and 0x0100 is never delivered.
- req_pc=0xFFFE streaming: delivered pcs 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- rst_n pulsed low mid-stream with a full queue: inst_valid=0 immediately. After release, the first delivered pc is RESET_PC. With IF_PERF_CNT_EN, both counters read 0.
